// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO on inferred block RAM with a registered read.
// Optional 16-bit saturating drop counter enabled by defining SYNC_FIFO_DROP_CNT_EN.
module sync_fifo #(
    parameter int unsigned addr_width  = 8,
    parameter int unsigned data_width  = 16,
    parameter int unsigned afull_level = 192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] din,
    input  logic                  wr_en,
    output logic [data_width-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [addr_width:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic                  overflow,
    input  logic                  clr_ovf,
    output logic [15:0]           drop_cnt
);
    localparam int unsigned Depth = 1 << addr_width;
    localparam logic [addr_width:0] DepthLvl = Depth[addr_width:0];
    localparam logic [addr_width:0] AfullLvl = afull_level[addr_width:0];

    logic [data_width-1:0] ram [Depth];
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [data_width-1:0] mid_data;
    logic                  mid_valid;
    logic [addr_width:0]   fetched;
    logic wr_accept, wr_drop, pop;
    logic head_free, head_from_mid, mid_free;
    logic pending, fetch, bypass, byp_head, byp_mid;

    assign empty = (level == '0);
    assign full  = (level == DepthLvl);
    assign afull = (level >= AfullLvl);

    assign wr_accept     = wr_en & ~full;
    assign wr_drop       = wr_en & full;
    assign pop           = dout_valid & dout_ready;
    assign head_free     = ~dout_valid | pop;
    assign head_from_mid = head_free & mid_valid;
    assign mid_free      = ~mid_valid | head_from_mid;

    // Entries held in the mid and head registers; anything beyond that still sits in RAM.
    assign fetched = {{addr_width{1'b0}}, mid_valid} + {{addr_width{1'b0}}, dout_valid};
    assign pending = (level > fetched);
    assign fetch   = pending & mid_free;

    // A write arriving while every stored entry is already prefetched skips the RAM read so the
    // non-empty FIFO never shows a bubble; an empty FIFO keeps the two-cycle fill latency.
    assign bypass   = wr_accept & ~empty & ~pending;
    assign byp_head = bypass & pop & ~mid_valid;
    assign byp_mid  = bypass & ~byp_head & mid_free;

    always_ff @(posedge clk) begin
        if (wr_accept) ram[wr_ptr] <= din;
        if (fetch) begin
            mid_data <= ram[rd_ptr];
        end else if (byp_mid) begin
            mid_data <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            mid_valid  <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (fetch | byp_head | byp_mid) rd_ptr <= rd_ptr + 1'b1;
            if (wr_accept & ~pop) begin
                level <= level + 1'b1;
            end else if (~wr_accept & pop) begin
                level <= level - 1'b1;
            end
            mid_valid  <= fetch | byp_mid | (mid_valid & ~head_from_mid);
            dout_valid <= head_from_mid | byp_head | (dout_valid & ~pop);
            if (head_from_mid) begin
                dout <= mid_data;
            end else if (byp_head) begin
                dout <= din;
            end
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef SYNC_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (clr_ovf) begin
            drop_cnt_q <= {15'b0, wr_drop};
        end else if (wr_drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue-based reference model.
module tb_sync_fifo;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int DEPTH = 16;
    localparam int AFL = 12;
`ifdef SYNC_FIFO_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, wr_en, dout_ready, clr_ovf;
    logic [DW-1:0] din, dout;
    logic dout_valid, empty, full, afull, overflow;
    logic [AW:0] level;
    logic [15:0] drop_cnt;

    sync_fifo #(.addr_width(AW), .data_width(DW), .afull_level(AFL)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .level(level), .empty(empty), .full(full), .afull(afull),
        .overflow(overflow), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: stored words with the edge index at which each was written.
    logic [DW-1:0] q_data[$];
    int            q_cyc[$];
    int            cyc = 0;
    bit            m_ovf = 0;
    int            m_drop = 0;

    function automatic logic [15:0] exp_drop();
        return CNT_EN ? 16'(m_drop) : 16'h0000;
    endfunction

    // Head must be visible once it has been stored for two edges.
    function automatic bit guaranteed();
        return q_data.size() > 0 && q_cyc[0] <= cyc - 3;
    endfunction

    function automatic bit ready_ok();
        return q_data.size() == 0 || guaranteed();
    endfunction

    task automatic clear_model();
        q_data.delete();
        q_cyc.delete();
        m_ovf = 0;
        m_drop = 0;
    endtask

    task automatic do_reset(input bit w);
        rst = 1'b1; wr_en = w; din = 16'hDEAD; dout_ready = 1'b0; clr_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0;
        cyc++;
        clear_model();
    endtask

    // Drive one edge; ready is only offered when the model knows the head is visible.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        bit acc, pop;
        wr_en = w; din = d; clr_ovf = c;
        dout_ready = r && ready_ok();
        acc = w && q_data.size() < DEPTH;
        pop = dout_ready && q_data.size() > 0;
        @(posedge clk);
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_cyc.pop_front());
        end
        if (acc) begin
            q_data.push_back(d);
            q_cyc.push_back(cyc);
        end
        if (w && !acc) begin
            m_ovf = 1;
            if (c) m_drop = 1;
            else if (m_drop < 65535) m_drop++;
        end else if (c) begin
            m_ovf = 0;
            m_drop = 0;
        end
        cyc++;
        #1;
        wr_en = 1'b0; clr_ovf = 1'b0; dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; din = '0; dout_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc += 2;
        clear_model();
        checks++; if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else passes++;
        checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passes++;
        checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passes++;
        checks++; if (afull !== 1'b0) $display("FAIL reset_afull: got %b want 0", afull); else passes++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dout_valid); else passes++;
        checks++; if (dout !== 16'h0) $display("FAIL reset_dout: got %h want 0000", dout); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else passes++;
        checks++; if (drop_cnt !== 16'h0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else passes++;
    endtask

    task automatic test_stream();
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i < 4 && guaranteed()) begin
                checks++;
                if (dout !== q_data[0]) $display("FAIL stream_pop: got %h want %h", dout, q_data[0]);
                else passes++;
            end
            step(i < 4, DW'(i + 1), 1'b1, 1'b0);
            if (i < 2) begin
                checks++;
                if (dout_valid !== 1'b0) $display("FAIL stream_latency: edge %0d got %b want 0", i, dout_valid);
                else passes++;
            end else if (q_data.size() > 0) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== q_data[0])
                    $display("FAIL stream_head: edge %0d got %b/%h want 1/%h", i, dout_valid, dout, q_data[0]);
                else passes++;
            end
            checks++;
            if (level !== 5'(q_data.size()) || empty !== (q_data.size() == 0))
                $display("FAIL stream_level: edge %0d got %0d/%b want %0d", i, level, empty, q_data.size());
            else passes++;
        end
        checks++; if (level !== 5'd0) $display("FAIL stream_final: got %0d want 0", level); else passes++;
    endtask

    task automatic test_fill_drop();
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, DW'($urandom), 1'b0, 1'b0);
            checks++;
            if (full !== (q_data.size() == DEPTH) || afull !== (q_data.size() >= AFL) ||
                level !== 5'(q_data.size()))
                $display("FAIL fill_flags: write %0d got lvl %0d full %b afull %b want lvl %0d",
                         i + 1, level, full, afull, q_data.size());
            else passes++;
        end
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== exp_drop())
            $display("FAIL fill_drop: got ovf %b cnt %0d want 1 %0d", overflow, drop_cnt, exp_drop());
        else passes++;
        for (int n = 0; n < 40 && q_data.size() > 0; n++) begin
            if (guaranteed()) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== q_data[0])
                    $display("FAIL drain_data: got %b/%h want 1/%h", dout_valid, dout, q_data[0]);
                else passes++;
            end
            step(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (afull !== (q_data.size() >= AFL) || level !== 5'(q_data.size()))
                $display("FAIL drain_flags: got lvl %0d afull %b want lvl %0d", level, afull, q_data.size());
            else passes++;
        end
        checks++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else passes++;
    endtask

    task automatic test_wrap();
        int sent = 0;
        int got = 0;
        do_reset(1'b0);
        for (int n = 0; n < 2000 && got < 40; n++) begin
            bit w, r, stall;
            logic [DW-1:0] prev;
            w = sent < 40 && q_data.size() < DEPTH && ($urandom % 4 != 0);
            r = ($urandom % 3 != 0) && ready_ok();
            stall = guaranteed() && !r;
            prev = (q_data.size() > 0) ? q_data[0] : '0;
            if (r && guaranteed()) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== q_data[0])
                    $display("FAIL wrap_data: item %0d got %b/%h want 1/%h", got, dout_valid, dout, q_data[0]);
                else passes++;
            end
            if (r && q_data.size() > 0) got++;
            step(w, DW'($urandom), r, 1'b0);
            if (w) sent++;
            if (stall) begin
                checks++;
                if (dout_valid !== 1'b1 || dout !== prev)
                    $display("FAIL wrap_stall: got %b/%h want 1/%h", dout_valid, dout, prev);
                else passes++;
            end
            checks++;
            if (level !== 5'(q_data.size()))
                $display("FAIL wrap_level: got %0d want %0d", level, q_data.size());
            else passes++;
        end
        checks++; if (got !== 40) $display("FAIL wrap_count: got %0d want 40", got); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", overflow); else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset(1'b0);
        step(1'b1, 16'hA5A5, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 16'h5A5A, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd1 || dout_valid !== 1'b1 || dout !== 16'h5A5A)
            $display("FAIL simul_lvl1: got %0d/%b/%h want 1/1/5a5a", level, dout_valid, dout);
        else passes++;
        step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (dout_valid !== 1'b1) $display("FAIL simul_glitch: got %b want 1", dout_valid); else passes++;
        for (int i = 0; i < 15; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        checks++; if (full !== 1'b1) $display("FAIL simul_full: got %b want 1", full); else passes++;
        step(1'b1, 16'hFFFF, 1'b1, 1'b0);
        checks++;
        if (level !== 5'd15 || overflow !== 1'b1 || drop_cnt !== exp_drop())
            $display("FAIL simul_fullpop: got %0d/%b/%0d want 15/1/%0d", level, overflow, drop_cnt, exp_drop());
        else passes++;
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1'b1, 16'h4321, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== exp_drop() || level !== 5'd16)
            $display("FAIL simul_clrdrop: got %b/%0d/%0d want 1/%0d/16", overflow, drop_cnt, level, exp_drop());
        else passes++;
        step(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0 || drop_cnt !== 16'h0)
            $display("FAIL simul_clr: got %b/%0d want 0/0", overflow, drop_cnt);
        else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        checks++; if (level !== 5'd9) $display("FAIL rstmid_pre: got %0d want 9", level); else passes++;
        do_reset(1'b1);
        checks++;
        if (level !== 5'd0 || dout_valid !== 1'b0 || empty !== 1'b1 || overflow !== 1'b0)
            $display("FAIL rstmid_post: got %0d/%b/%b/%b want 0/0/1/0", level, dout_valid, empty, overflow);
        else passes++;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (empty !== 1'b1 || dout_valid !== 1'b0)
            $display("FAIL rstmid_ignored: got %b/%b want 1/0", empty, dout_valid);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drop();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
